// File: rtl/drawbridge_pkg.sv
// Shared definitions for the drawbridge controller: state encodings and
// motor direction constants used by the top level and the bench.
package drawbridge_pkg;

  typedef enum logic [2:0] {
    FLAT     = 3'd0,
    CLEARING = 3'd1,
    LIFTING  = 3'd2,
    UPRIGHT  = 3'd3,
    LOWERING = 3'd4,
    FAULT    = 3'd5
  } state_t;

  localparam logic MDIR_UP = 1'b1;
  localparam logic MDIR_DN = 1'b0;

endpackage

// File: rtl/car_counter_sat.sv
// Saturating car counter: adds per-lane entries, subtracts per-lane exits,
// clamps to the counter range and flags any clamp for that cycle.
module car_counter_sat #(
  parameter int LANES = 2,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [LANES-1:0] cain,
  input  logic [LANES-1:0] cao,
  output logic [CNT_W-1:0] count,
  output logic             clamp
);

  // Wide enough for count + all entries, plus a sign bit for underflow.
  localparam int SW = CNT_W + $clog2(LANES) + 1;
  localparam logic signed [SW-1:0] MAX = SW'((2 ** CNT_W) - 1);

  logic [SW-1:0]        n_in;
  logic [SW-1:0]        n_out;
  logic signed [SW-1:0] sum;
  logic [CNT_W-1:0]     count_next;

  // Popcount both sensor vectors and form the clamped next count.
  always_comb begin
    n_in  = '0;
    n_out = '0;
    for (int i = 0; i < LANES; i++) begin
      n_in  = n_in + SW'(cain[i]);
      n_out = n_out + SW'(cao[i]);
    end
    sum        = signed'(SW'(count) + n_in - n_out);
    clamp      = 1'b0;
    count_next = sum[CNT_W-1:0];
    if (sum[SW-1]) begin
      clamp      = 1'b1;
      count_next = '0;
    end else if (sum > MAX) begin
      clamp      = 1'b1;
      count_next = MAX[CNT_W-1:0];
    end
  end

  // Count register; active in every controller state.
  always_ff @(posedge clk) begin
    if (!rst_n) count <= '0;
    else        count <= count_next;
  end

endmodule

// File: rtl/drawbridge_ctrl_param.sv
// Drawbridge controller: holds traffic, waits for an empty deck, drives the
// lift motor up/down, and latches FAULT if motion takes too long.
module drawbridge_ctrl_param
  import drawbridge_pkg::*;
#(
  parameter int LANES        = 2,
  parameter int CNT_W        = 4,
  parameter int CLEAR_DELAY  = 4,
  parameter int MOVE_TIMEOUT = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [LANES-1:0] CAIN,
  input  logic [LANES-1:0] CAO,
  input  logic             MD,
  input  logic             PB,
  input  logic             BS,
  input  logic             H,
  input  logic             L,
  output logic             MT,
  output logic             MDIR,
  output logic             AL,
  output logic             TFL,
  output logic [CNT_W-1:0] CarCount,
  output logic [2:0]       State
);

  localparam int CW = $clog2(CLEAR_DELAY + 1);
  localparam int MW = $clog2(MOVE_TIMEOUT + 1);
  localparam logic [CW-1:0] CLR_TGT = CW'(CLEAR_DELAY);
  localparam logic [MW-1:0] MV_TGT  = MW'(MOVE_TIMEOUT);

  state_t         state_reg, state_next;
  logic [CW-1:0]  clr_reg, clr_next;
  logic [MW-1:0]  mv_reg, mv_next;
  logic           pb_q;
  logic           pb_edge, req_up, req_dn;
  logic           lower_alarm, al_next;
  logic           clamp;

  car_counter_sat #(
    .LANES (LANES),
    .CNT_W (CNT_W)
  ) u_counter (
    .clk   (Clk),
    .rst_n (Reset),
    .cain  (CAIN),
    .cao   (CAO),
    .count (CarCount),
    .clamp (clamp)
  );

  // Next-state, timer and alarm decisions from the current state and sensors.
  always_comb begin
    state_next  = state_reg;
    clr_next    = '0;
    mv_next     = '0;
    lower_alarm = 1'b0;
    pb_edge     = PB & ~pb_q;
    req_up      = MD ? pb_edge : BS;
    req_dn      = MD ? pb_edge : ~BS;
    case (state_reg)
      FLAT: begin
        if (req_up) state_next = CLEARING;
      end
      CLEARING: begin
        if (CarCount == '0)
          clr_next = (clr_reg == CLR_TGT) ? clr_reg : clr_reg + CW'(1);
        // Boat leaving in auto mode wins over a completed clear delay.
        if (!MD && !BS)
          state_next = FLAT;
        else if (CarCount == '0 && clr_next == CLR_TGT)
          state_next = LIFTING;
      end
      LIFTING: begin
        mv_next = (mv_reg == MV_TGT) ? mv_reg : mv_reg + MW'(1);
        if (H)                      state_next = UPRIGHT;
        else if (mv_next == MV_TGT) state_next = FAULT;
      end
      UPRIGHT: begin
        if (req_dn) state_next = LOWERING;
      end
      LOWERING: begin
        mv_next = (mv_reg == MV_TGT) ? mv_reg : mv_reg + MW'(1);
        // Deck-high while going down means a broken sensor; flag it only.
        lower_alarm = H;
        if (L)                      state_next = FLAT;
        else if (mv_next == MV_TGT) state_next = FAULT;
      end
      FAULT: begin
        state_next = FAULT;
      end
      default: begin
        state_next = FAULT;
      end
    endcase
    al_next = clamp | (H & L) | lower_alarm | (state_next == FAULT);
  end

  // State, timers and all outputs registered together from the next state.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_reg <= FLAT;
      clr_reg   <= '0;
      mv_reg    <= '0;
      pb_q      <= 1'b0;
      MT        <= 1'b0;
      MDIR      <= MDIR_DN;
      AL        <= 1'b0;
      TFL       <= 1'b0;
    end else begin
      state_reg <= state_next;
      clr_reg   <= clr_next;
      mv_reg    <= mv_next;
      pb_q      <= PB;
      MT        <= (state_next == LIFTING) || (state_next == LOWERING);
      MDIR      <= (state_next == LIFTING) ? MDIR_UP : MDIR_DN;
      AL        <= al_next;
      TFL       <= (state_next != FLAT);
    end
  end

  assign State = state_reg;

endmodule

// File: tb/tb_drawbridge_ctrl_param.sv
// Bench for drawbridge_ctrl_param: directed stimulus, a cycle-level reference
// model checked every clock, and literal expectations at key points.
module tb_drawbridge_ctrl_param;

  localparam int LANES        = 2;
  localparam int CNT_W        = 4;
  localparam int CLEAR_DELAY  = 4;
  localparam int MOVE_TIMEOUT = 16;
  localparam int CMAX         = (1 << CNT_W) - 1;

  logic             Clk = 1'b0;
  logic             Reset;
  logic [LANES-1:0] CAIN, CAO;
  logic             MD, PB, BS, H, L;
  logic             MT, MDIR, AL, TFL;
  logic [CNT_W-1:0] CarCount;
  logic [2:0]       State;

  int errors = 0;
  int checks = 0;

  drawbridge_ctrl_param #(
    .LANES(LANES), .CNT_W(CNT_W), .CLEAR_DELAY(CLEAR_DELAY), .MOVE_TIMEOUT(MOVE_TIMEOUT)
  ) dut (
    .Clk(Clk), .Reset(Reset), .CAIN(CAIN), .CAO(CAO), .MD(MD), .PB(PB), .BS(BS),
    .H(H), .L(L), .MT(MT), .MDIR(MDIR), .AL(AL), .TFL(TFL),
    .CarCount(CarCount), .State(State)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: states as small integers, dwell counts as plain cycle tallies.
  int m_state = 0, m_count = 0, m_streak = 0, m_moved = 0;
  bit m_pb = 0, m_mt = 0, m_mdir = 0, m_al = 0, m_tfl = 0;

  always @(posedge Clk) begin
    int n, ns;
    bit pbe, up, dn, al;
    if (!Reset) begin
      m_state = 0; m_count = 0; m_streak = 0; m_moved = 0;
      m_pb = 0; m_mt = 0; m_mdir = 0; m_al = 0; m_tfl = 0;
    end else begin
      n  = m_count + $countones(CAIN) - $countones(CAO);
      al = (n < 0) || (n > CMAX);
      if (n < 0)    n = 0;
      if (n > CMAX) n = CMAX;
      if (H && L) al = 1;
      pbe = PB && !m_pb;
      up  = MD ? pbe : BS;
      dn  = MD ? pbe : !BS;
      ns  = m_state;
      case (m_state)
        0: if (up) ns = 1;
        1: begin
          m_streak = (m_count == 0) ? m_streak + 1 : 0;
          if (!MD && !BS) ns = 0;
          else if (m_streak >= CLEAR_DELAY) ns = 2;
        end
        2: begin
          m_moved++;
          if (H) ns = 3;
          else if (m_moved >= MOVE_TIMEOUT) ns = 5;
        end
        3: if (dn) ns = 4;
        4: begin
          m_moved++;
          if (H) al = 1;
          if (L) ns = 0;
          else if (m_moved >= MOVE_TIMEOUT) ns = 5;
        end
        default: ns = 5;
      endcase
      if (ns != m_state) begin
        m_streak = 0;
        m_moved  = 0;
      end
      if (ns == 5) al = 1;
      m_state = ns;
      m_count = n;
      m_pb    = PB;
      m_al    = al;
      m_mt    = (ns == 2) || (ns == 4);
      m_mdir  = (ns == 2);
      m_tfl   = (ns != 0);
    end
    #1;
    check("cyc_State", 32'(State), 32'(m_state));
    check("cyc_CarCount", 32'(CarCount), 32'(m_count));
    check("cyc_MT", 32'(MT), 32'(m_mt));
    check("cyc_AL", 32'(AL), 32'(m_al));
    check("cyc_TFL", 32'(TFL), 32'(m_tfl));
    if (m_mt) check("cyc_MDIR", 32'(MDIR), 32'(m_mdir));
  end

  task automatic step(input int n);
    repeat (n) @(negedge Clk);
  endtask

  initial begin
    Reset = 1'b0; CAIN = '0; CAO = '0; MD = 1'b0; PB = 1'b0; BS = 1'b0; H = 1'b0; L = 1'b1;

    // 1: reset then three entries on lane 0
    step(1);
    $display("txn reset: State=%0d CarCount=%0d", State, CarCount);
    check("rst_State", 32'(State), 32'd0);
    check("rst_CarCount", 32'(CarCount), 32'd0);
    check("rst_MT", 32'(MT), 32'd0);
    check("rst_AL", 32'(AL), 32'd0);
    check("rst_TFL", 32'(TFL), 32'd0);
    check("rst_MDIR", 32'(MDIR), 32'd0);
    Reset = 1'b1; CAIN = 2'b01;
    step(3);
    CAIN = '0;
    $display("txn entries: CarCount=%0d", CarCount);
    check("t1_CarCount", 32'(CarCount), 32'd3);
    check("t1_State", 32'(State), 32'd0);
    check("t1_TFL", 32'(TFL), 32'd0);
    check("t1_AL", 32'(AL), 32'd0);

    // 2: auto lift with cars on deck
    CAO = 2'b01; L = 1'b0;
    step(1);
    CAO = '0;
    check("t2_CarCount2", 32'(CarCount), 32'd2);
    BS = 1'b1;
    step(1);
    $display("txn boat: State=%0d TFL=%0d", State, TFL);
    check("t2_State_clr", 32'(State), 32'd1);
    check("t2_TFL", 32'(TFL), 32'd1);
    CAO = 2'b11;
    step(1);
    CAO = '0;
    check("t2_CarCount0", 32'(CarCount), 32'd0);
    step(3);
    check("t2_State_wait", 32'(State), 32'd1);
    step(1);
    $display("txn lifting: State=%0d MT=%0d MDIR=%0d", State, MT, MDIR);
    check("t2_State_lift", 32'(State), 32'd2);
    check("t2_MT", 32'(MT), 32'd1);
    check("t2_MDIR", 32'(MDIR), 32'd1);
    H = 1'b1;
    step(1);
    check("t2_State_up", 32'(State), 32'd3);
    check("t2_MT_up", 32'(MT), 32'd0);

    // 3: auto lower with impossible-sensor alarm
    BS = 1'b0; H = 1'b0;
    step(1);
    $display("txn lowering: State=%0d MT=%0d MDIR=%0d", State, MT, MDIR);
    check("t3_State_low", 32'(State), 32'd4);
    check("t3_MT", 32'(MT), 32'd1);
    check("t3_MDIR", 32'(MDIR), 32'd0);
    H = 1'b1;
    step(1);
    H = 1'b0;
    check("t3_AL", 32'(AL), 32'd1);
    check("t3_State_stay", 32'(State), 32'd4);
    L = 1'b1;
    step(1);
    check("t3_State_flat", 32'(State), 32'd0);
    check("t3_TFL", 32'(TFL), 32'd0);
    check("t3_AL_clear", 32'(AL), 32'd0);

    // 4: manual mode, single PB edge per transition
    MD = 1'b1; BS = 1'b1;
    step(2);
    check("t4_BS_ignored", 32'(State), 32'd0);
    PB = 1'b1;
    step(1);
    $display("txn pb edge: State=%0d", State);
    check("t4_State_clr", 32'(State), 32'd1);
    step(2);
    check("t4_State_hold", 32'(State), 32'd1);
    PB = 1'b0; L = 1'b0;
    step(2);
    check("t4_State_lift", 32'(State), 32'd2);
    H = 1'b1;
    step(1);
    check("t4_State_up", 32'(State), 32'd3);
    PB = 1'b1; H = 1'b0;
    step(1);
    check("t4_State_low", 32'(State), 32'd4);
    L = 1'b1; PB = 1'b0;
    step(1);
    check("t4_State_flat", 32'(State), 32'd0);

    // 5: watchdog in LIFTING
    MD = 1'b0; BS = 1'b1; L = 1'b0;
    step(5);
    check("t5_State_lift", 32'(State), 32'd2);
    step(15);
    check("t5_State_still", 32'(State), 32'd2);
    step(1);
    $display("txn watchdog: State=%0d AL=%0d MT=%0d TFL=%0d", State, AL, MT, TFL);
    check("t5_State_fault", 32'(State), 32'd5);
    check("t5_AL", 32'(AL), 32'd1);
    check("t5_MT", 32'(MT), 32'd0);
    check("t5_TFL", 32'(TFL), 32'd1);
    BS = 1'b0; L = 1'b1;
    step(3);
    check("t5_fault_held", 32'(State), 32'd5);
    check("t5_AL_held", 32'(AL), 32'd1);
    Reset = 1'b0;
    step(1);
    Reset = 1'b1;
    check("t5_State_rst", 32'(State), 32'd0);
    check("t5_AL_rst", 32'(AL), 32'd0);

    // 6: counter bounds
    CAO = 2'b01;
    step(1);
    CAO = '0;
    $display("txn underflow: CarCount=%0d AL=%0d", CarCount, AL);
    check("t6_under_cnt", 32'(CarCount), 32'd0);
    check("t6_under_AL", 32'(AL), 32'd1);
    step(1);
    check("t6_AL_pulse", 32'(AL), 32'd0);
    CAIN = 2'b11;
    step(7);
    check("t6_cnt14", 32'(CarCount), 32'd14);
    check("t6_AL14", 32'(AL), 32'd0);
    step(1);
    check("t6_cnt_sat", 32'(CarCount), 32'd15);
    check("t6_over_AL", 32'(AL), 32'd1);
    step(1);
    $display("txn overflow: CarCount=%0d AL=%0d", CarCount, AL);
    check("t6_cnt_hold", 32'(CarCount), 32'd15);
    check("t6_over_AL2", 32'(AL), 32'd1);
    CAIN = 2'b01; CAO = 2'b01;
    step(1);
    check("t6_cancel_cnt", 32'(CarCount), 32'd15);
    check("t6_cancel_AL", 32'(AL), 32'd0);
    CAIN = 2'b01; CAO = 2'b10;
    step(1);
    CAIN = '0; CAO = '0;
    check("t6_cross_cnt", 32'(CarCount), 32'd15);
    step(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
